// File: rtl/branch_predict_npc.sv
// Next-PC generator with a direct-mapped branch target buffer and 2-bit counters.
// A misprediction resolved in execute produces a registered one-cycle redirect.
module branch_predict_npc #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_if,
  output logic [31:0] topc,
  output logic        pred_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] correctPC,
  output logic        jumpSuccess
);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [29:0]      r_target [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];

  logic        r_jump;
  logic [31:0] r_cpc;

  logic [IDX_W-1:0] w_if_idx;
  logic [TAG_W-1:0] w_if_tag;
  logic             w_if_hit;
  logic [IDX_W-1:0] w_ex_idx;
  logic [TAG_W-1:0] w_ex_tag;
  logic             w_ex_hit;
  logic [31:0]      w_ex_seq;
  logic [31:0]      w_actual;
  logic [31:0]      w_predicted;
  logic             w_mispredict;
  logic             w_alloc;
  logic             w_upd;
  logic             w_inval;
  logic [1:0]       w_ctr_cur;
  logic [1:0]       w_ctr_next;

  // Fetch-side lookup; reads the array as it stood before this edge's update.
  assign w_if_idx   = pc_if[IDX_W+1:2];
  assign w_if_tag   = pc_if[31:IDX_W+2];
  assign w_if_hit   = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken = w_if_hit && r_ctr[w_if_idx][1];
  assign topc       = pred_taken ? {r_target[w_if_idx], 2'b00} : pc_if + 32'd4;

  assign w_ex_idx     = ex_pc[IDX_W+1:2];
  assign w_ex_tag     = ex_pc[31:IDX_W+2];
  assign w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
  assign w_ex_seq     = ex_pc + 32'd4;
  assign w_actual     = (ex_is_branch && ex_taken) ? ex_target : w_ex_seq;
  assign w_predicted  = ex_pred_taken ? ex_pred_target : w_ex_seq;
  assign w_mispredict = ex_valid && (w_actual != w_predicted);

  assign w_ctr_cur = r_ctr[w_ex_idx];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    w_alloc    = 1'b0;
    w_upd      = 1'b0;
    w_inval    = 1'b0;
    w_ctr_next = w_ctr_cur;
    if (ex_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_next = w_ctr_cur + 2'd1;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_next = w_ctr_cur - 2'd1;
    end
    if (ex_valid) begin
      if (ex_is_branch) begin
        if (w_ex_hit)      w_upd   = 1'b1;
        else if (ex_taken) w_alloc = 1'b1;
      end else if (w_ex_hit) begin
        w_inval = 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (w_alloc) begin
      r_valid[w_ex_idx] <= 1'b1;
      r_ctr[w_ex_idx]   <= 2'b10;
    end else if (w_upd) begin
      r_ctr[w_ex_idx] <= w_ctr_next;
    end else if (w_inval) begin
      r_valid[w_ex_idx] <= 1'b0;
    end
  end

  // NOTE: tag and target are only meaningful behind a set valid bit, so this
  // storage is deliberately left without a reset.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_ex_idx]    <= w_ex_tag;
      r_target[w_ex_idx] <= ex_target[31:2];
    end else if (w_upd && ex_taken) begin
      r_target[w_ex_idx] <= ex_target[31:2];
    end
  end

  // Redirect pulse; reset wins so a pending redirect is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_jump <= 1'b0;
      r_cpc  <= 32'h0000_3000;
    end else begin
      r_jump <= w_mispredict;
      if (w_mispredict) r_cpc <= w_actual;
    end
  end

  assign jumpSuccess = r_jump;
  assign correctPC   = r_cpc;

endmodule
